// File: rtl/rbm_acc_pkg.sv
// Shared types and constants for the RBM hidden-unit accumulator.
// Build option: RBM_ACC_EXACT_ADD_EN selects the exact adder.
package rbm_acc_pkg;

   typedef enum logic {
      ACC,
      DONE
   } state_t;

   localparam int DATA_W       = 16;
   localparam int SEG_W        = 8;
   localparam int N_INPUTS_DEF = 784;
   localparam int CNT_W_DEF    = 10;

endpackage

// File: rtl/rbm_seg_adder.sv
// Combinational 16-bit adder, segmented with speculated carry by default.
// Build option: RBM_ACC_EXACT_ADD_EN makes it an exact 16-bit sum.
module rbm_seg_adder
   import rbm_acc_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] sum
);

`ifdef RBM_ACC_EXACT_ADD_EN

   assign sum = a + b;

`else

   logic [SEG_W-1:0] sl;
   logic [SEG_W-1:0] sh;

   // Low byte carry-out is dropped; a[0] stands in as the high-byte carry.
   assign sl  = a[SEG_W-1:0] + b[SEG_W-1:0];
   assign sh  = a[DATA_W-1:SEG_W] + b[DATA_W-1:SEG_W]
              + {{(SEG_W-1){1'b0}}, a[0]};
   assign sum = {sh, sl};

`endif

endmodule

// File: rtl/rbm_hidden_accumulator.sv
// Frame accumulator for one RBM hidden unit's pre-activation sum.
// Build option: RBM_ACC_EXACT_ADD_EN swaps in the exact adder.
module rbm_hidden_accumulator
   import rbm_acc_pkg::*;
#(
   parameter int N_INPUTS = N_INPUTS_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_weight,
   input  logic              in_vis,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_overrun
);

   state_t             state;
   state_t             state_nxt;
   logic [DATA_W-1:0]  acc;
   logic [DATA_W-1:0]  add_sum;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_inc;
   logic               overrun;
   logic               live;
   logic               accept;
   logic               at_limit;
   logic               drain;

   rbm_seg_adder u_add (
      .a   (acc),
      .b   (in_weight),
      .sum (add_sum)
   );

   assign cnt_inc  = cnt + 1'b1;
   assign at_limit = (cnt_inc == CNT_W'(N_INPUTS));
   assign accept   = in_valid & in_ready;
   assign drain    = (state == DONE) & out_ready;

   assign in_ready    = live & (state == ACC);
   assign out_valid   = (state == DONE);
   assign out_sum     = acc;
   assign out_count   = cnt;
   assign out_overrun = overrun;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACC;
      else        state <= state_nxt;
   end

   // Next state: close the frame on last/limit, reopen on drain.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ACC:  if (accept && (in_last || at_limit)) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   // Accumulator, beat counter and overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live    <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         overrun <= 1'b0;
      end else begin
         live <= 1'b1;
         if (accept) begin
            if (in_vis) acc <= add_sum;
            cnt <= cnt_inc;
            if (at_limit && !in_last) overrun <= 1'b1;
         end else if (drain) begin
            acc     <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rbm_hidden_accumulator.sv
// Self-checking bench for rbm_hidden_accumulator (N_INPUTS=4).
// Honors RBM_ACC_EXACT_ADD_EN to pick the reference adder.
module tb_rbm_hidden_accumulator;

   localparam int N  = 4;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_weight = '0;
   logic          in_vis = 1'b0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_sum;
   logic [CW-1:0] out_count;
   logic          out_overrun;

   int checks = 0;
   int failures = 0;
   int m_sum = 0;
   int m_cnt = 0;

   rbm_hidden_accumulator #(.N_INPUTS(N), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_weight   (in_weight),
      .in_vis      (in_vis),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_count   (out_count),
      .out_overrun (out_overrun)
   );

   always #5 clk = ~clk;

   function automatic int m_add(input int a, input int b);
      int lo;
      int hi;
`ifdef RBM_ACC_EXACT_ADD_EN
      return (a + b) % 65536;
`else
      lo = (a % 256 + b % 256) % 256;
      hi = (a / 256 + b / 256 + a % 2) % 256;
      return hi * 256 + lo;
`endif
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int w, input bit v, input bit last);
      int t = 0;
      while (!in_ready && t < 20) begin
         tick();
         t++;
      end
      chk("in_ready_wait", int'(in_ready), 1);
      in_valid  = 1'b1;
      in_weight = 16'(w);
      in_vis    = v;
      in_last   = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_vis   = 1'b0;
      if (v) m_sum = m_add(m_sum, w);
      m_cnt++;
   endtask

   task automatic finish(input int es, input int ec, input int eo,
                         input int hold);
      int t = 0;
      while (!out_valid && t < 20) begin
         tick();
         t++;
      end
      chk("out_valid", int'(out_valid), 1);
      for (int i = 0; i <= hold; i++) begin
         chk("out_sum", int'(out_sum), es);
         chk("out_count", int'(out_count), ec);
         chk("out_overrun", int'(out_overrun), eo);
         chk("in_ready_done", int'(in_ready), 0);
         if (i < hold) begin
            tick();
            chk("valid_hold", int'(out_valid), 1);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("valid_clr", int'(out_valid), 0);
      chk("in_ready_back", int'(in_ready), 1);
      chk("ovr_clr", int'(out_overrun), 0);
      chk("cnt_clr", int'(out_count), 0);
      m_sum = 0;
      m_cnt = 0;
   endtask

   initial begin
      int len;
      bit nolast;
      int w;
      bit v;

      repeat (3) tick();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_sum", int'(out_sum), 0);
      chk("rst_count", int'(out_count), 0);
      chk("rst_ovr", int'(out_overrun), 0);
      rst_n = 1'b1;
      tick();
      chk("rst_ready", int'(in_ready), 1);

      send(16'h0001, 1, 0);
      send(16'h00FF, 1, 1);
      finish(16'h0100, 2, 0, 0);

      send(16'h0080, 1, 0);
      send(16'h0080, 1, 1);
`ifdef RBM_ACC_EXACT_ADD_EN
      finish(16'h0100, 2, 0, 1);
`else
      finish(16'h0000, 2, 0, 1);
`endif

      send(16'h0003, 1, 0);
      send(16'h0001, 1, 1);
`ifdef RBM_ACC_EXACT_ADD_EN
      finish(16'h0004, 2, 0, 0);
`else
      finish(16'h0104, 2, 0, 0);
`endif

      send(16'h0003, 1, 0);
      send(16'h1234, 0, 0);
      send(16'h0000, 0, 1);
      finish(16'h0003, 3, 0, 0);

      for (int i = 0; i < N; i++) send(16'h0010, 1, 0);
      finish(16'h0040, 4, 1, 5);

      for (int i = 0; i < N - 1; i++) send(16'h0010, 1, 0);
      send(16'h0010, 1, 1);
      finish(16'h0040, 4, 0, 0);

      send(16'h1111, 1, 0);
      send(16'h0202, 1, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_valid", int'(out_valid), 0);
      chk("mid_sum", int'(out_sum), 0);
      chk("mid_count", int'(out_count), 0);
      chk("mid_ovr", int'(out_overrun), 0);
      m_sum = 0;
      m_cnt = 0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("mid_ready", int'(in_ready), 1);
      send(16'h7FFF, 1, 1);
      finish(16'h7FFF, 1, 0, 0);

      for (int f = 0; f < 30; f++) begin
         len    = $urandom_range(1, N);
         nolast = (len == N) && ($urandom_range(0, 1) == 1);
         for (int i = 0; i < len; i++) begin
            w = int'($urandom_range(0, 65535));
            v = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 2)) tick();
            send(w, v, (i == len - 1) && !nolast);
         end
         finish(m_sum, m_cnt, int'(nolast), $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rbm_hidden_accumulator.md
Name: rbm_hidden_accumulator

Overview:
- Downstream consumer of the 16-bit approximate segmented adder (8-bit split, speculated carry).
- Accumulates one RBM hidden unit's pre-activation over a frame of streamed (weight, visible-bit) beats.
- Presents the 16-bit sum to the activation/sigmoid stage over a valid/ready handshake.
- The adder is instantiated inside this block as its combinational datapath; this block supplies the register, sequencing and handshakes around it.

Parameters:
- N_INPUTS, 784: maximum beats per frame (visible units).
- CNT_W, 10: beat-counter width; must satisfy 2^CNT_W > N_INPUTS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_weight  input  16  signed weight w_ij, two's complement.
- in_vis  input  1  visible unit state v_i (binary).
- in_last  input  1  final beat of frame.
- out_valid  output  1  frame sum available.
- out_ready  input  1  downstream accepts sum.
- out_sum  output  16  accumulated pre-activation.
- out_count  output  CNT_W  beats accepted in the frame.
- out_overrun  output  1  frame was force-terminated at N_INPUTS without in_last.

Behaviour:
- Reset (async, rst_n=0):
  - state=ACC, acc=0, cnt=0.
  - out_valid=0, out_sum=0, out_count=0, out_overrun=0.
  - in_ready=1 from the first clock edge after rst_n deasserts.
- States: ACC, DONE.
- ACC:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid & in_ready.
  - On accept with in_vis=1: acc <= add(A=acc, B=in_weight).
  - On accept with in_vis=0: acc unchanged. Do not add zero; the approximate adder would inject acc[0] into the high byte.
  - Every accept increments cnt.
  - Transition to DONE when the accepted beat has in_last=1, or when cnt+1 == N_INPUTS.
  - If the N_INPUTS termination fires without in_last, out_overrun <= 1.
  - in_last and the count limit on the same beat: normal termination, overrun=0.
- add() in approximate mode:
  - SL = A[7:0] + B[7:0] (9-bit).
  - SH = A[15:8] + B[15:8] + A[0] (9-bit).
  - result = {SH[7:0], SL[7:0]}.
  - The carry-in to the high byte is the accumulator's LSB, never B[0] or SL[8].
- Latency: acc reflects a beat one cycle after acceptance. out_valid rises the cycle after the terminating beat is accepted.
- DONE:
  - in_ready=0, out_valid=1.
  - out_sum=acc and out_count=cnt, held stable until the handshake.
  - On out_valid & out_ready: acc<=0, cnt<=0, overrun<=0, state<=ACC.
  - in_ready returns to 1 the following cycle; there is no frame overlap.
- Width rules:
  - Wrap-around modulo 2^16, no saturation.
  - No overflow flag from the adder.
- Zero-length frames are impossible; the minimum frame is one beat.
- out_valid and out_ready are independent of in_valid; in_ready depends only on state. There are no combinational paths from inputs to outputs.
- Reset asserted mid-frame: partial sum discarded, all state returns to reset values immediately.

Optional Feature:
- Macro: RBM_ACC_EXACT_ADD_EN.
- Defined: add() is the exact 16-bit sum (A+B)[15:0]; used as a golden/debug build.
- Undefined (default): add() is the approximate segmented sum above.
- All control and handshake behaviour is identical in both builds.

Decomposition:
- Shared package rbm_acc_pkg:
  - state enum {ACC, DONE}.
  - DATA_W=16, SEG_W=8 constants.
  - default N_INPUTS.
- One sub-module: rbm_seg_adder, combinational 16-bit A+B.
  - Contains the approximate/exact selection under RBM_ACC_EXACT_ADD_EN.
  - Reusable by other accumulators.

Test Plan:
- Carry speculation hit:
  - Beats (0x0001,v=1), (0x00FF,v=1,last) -> out_sum=0x0100 in both builds.
- Carry loss:
  - Beats (0x0080,1), (0x0080,1,last).
  - Approximate -> out_sum=0x0000; exact build -> 0x0100.
  - out_count=2.
- False carry:
  - Beats (0x0003,1), (0x0001,1,last).
  - Approximate -> 0x0104; exact -> 0x0004.
- Visible gating:
  - Beats (0x0003,1), (0x1234,0), (0x0000,0,last) -> out_sum=0x0003, out_count=3.
- Overrun and backpressure:
  - Set N_INPUTS=4, send 4 beats of (0x0010,1) with no last, then hold out_ready=0 for 5 cycles.
  - Expect out_valid high, sum 0x0040, out_overrun=1 and in_ready=0, all held stable.
  - out_ready=1 -> next cycle in_ready=1 and flags cleared.
- Async reset mid-frame:
  - Assert rst_n=0 after 2 beats -> outputs zero immediately.
  - A new 1-beat frame (0x7FFF,1,last) -> 0x7FFF.
